btb_ctrl: RTL and testbench

Controller that owns a bank of `btb_entry` slots and sequences every operation on them. Lookup results from the fetch stage are merged combinationally. Branch resolutions from execute are accepted through a valid/ready handshake and turned into VERIFY or INSERT ops on exactly one slot, with the victim chosen by first-empty, then round-robin. Flush requests are turned into a bank-wide CLEAR. It sits between fetch/execute and the BTB entry array.

---
 rtl/btb_ctrl.sv | 173 +++++++++++++++++
 tb/tb_btb_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_ctrl.sv
// rtl/btb_ctrl.sv - BTB controller: lookup merge, resolve/issue sequencing, flush
//
// Purpose: owns a bank of btb_entry slots. Merges per-slot lookup results
// combinationally. Turns branch resolutions into VERIFY/INSERT ops on one
// slot and turns flush requests into a bank-wide CLEAR.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   clear_req                     flush request (level)
//   upd_valid/upd_ready           resolution handshake
//   upd_pc/upd_target/upd_taken   resolved branch
//   ent_hit/ent_update_hit/ent_empty/ent_prediction/ent_target  slot status
//   ent_enable/ent_op/ent_in_pc/ent_in_target                  slot command
//   lookup_hit/lookup_taken/lookup_target                      fetch result
//   mispredict, busy              status
module btb_ctrl #(
  parameter int N_ENTRIES = 4,
  parameter int IDX_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_req,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [15:0]             upd_pc,
  input  logic [15:0]             upd_target,
  input  logic                    upd_taken,
  input  logic [N_ENTRIES-1:0]    ent_hit,
  input  logic [N_ENTRIES-1:0]    ent_update_hit,
  input  logic [N_ENTRIES-1:0]    ent_empty,
  input  logic [N_ENTRIES-1:0]    ent_prediction,
  input  logic [16*N_ENTRIES-1:0] ent_target,
  output logic [N_ENTRIES-1:0]    ent_enable,
  output logic [2:0]              ent_op,
  output logic [10:0]             ent_in_pc,
  output logic [15:0]             ent_in_target,
  output logic                    lookup_hit,
  output logic                    lookup_taken,
  output logic [15:0]             lookup_target,
  output logic                    mispredict,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RESOLVE, S_ISSUE} state_t;

  localparam logic [N_ENTRIES-1:0] ONE = {{(N_ENTRIES-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic             clear_pend;
  logic [IDX_W-1:0] rr_ptr;
  logic [10:0]      cap_tag;
  logic [15:0]      cap_target;
  logic             cap_taken;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic             pred;
  logic [IDX_W-1:0] victim;
  // Victim was taken from rr_ptr because no slot was empty.
  logic             victim_full;

  // Lowest-index set bit; scanning downward lets the lowest index win.
  function automatic logic [IDX_W-1:0] lowest(input logic [N_ENTRIES-1:0] v);
    lowest = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) lowest = IDX_W'(i);
    end
  endfunction

  logic             clear_any;
  logic [IDX_W-1:0] upd_hit_idx;
  logic [IDX_W-1:0] lk_idx;

  assign clear_any   = clear_req | clear_pend;
  assign upd_hit_idx = lowest(ent_update_hit);
  assign lk_idx      = lowest(ent_hit);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      clear_pend  <= 1'b0;
      rr_ptr      <= '0;
      cap_tag     <= '0;
      cap_target  <= '0;
      cap_taken   <= 1'b0;
      hit_any     <= 1'b0;
      hit_idx     <= '0;
      pred        <= 1'b0;
      victim      <= '0;
      victim_full <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (!clear_any && upd_valid) begin
            cap_tag    <= upd_pc[15:5];
            cap_target <= upd_target;
            cap_taken  <= upd_taken;
          end
        end
        S_CLEAR: begin
          clear_pend <= 1'b0;
          rr_ptr     <= '0;
        end
        S_RESOLVE: begin
          hit_any     <= |ent_update_hit;
          hit_idx     <= upd_hit_idx;
          pred        <= ent_prediction[upd_hit_idx];
          victim      <= (|ent_empty) ? lowest(ent_empty) : rr_ptr;
          victim_full <= ~|ent_empty;
          if (clear_req) clear_pend <= 1'b1;
        end
        S_ISSUE: begin
          // N_ENTRIES is a power of two, so the natural wrap is modulo N.
          if (!hit_any && victim_full) rr_ptr <= rr_ptr + 1'b1;
          if (clear_req) clear_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (clear_any)      state_nxt = S_CLEAR;
        else if (upd_valid) state_nxt = S_RESOLVE;
      end
      S_CLEAR:   state_nxt = S_IDLE;
      S_RESOLVE: state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so they hold all cycle.
  always_comb begin
    ent_op     = 3'b000;
    ent_enable = '0;
    mispredict = 1'b0;
    case (state)
      S_CLEAR: begin
        ent_op     = 3'b111;
        ent_enable = '1;
      end
      S_ISSUE: begin
        if (hit_any) begin
          ent_op     = {2'b01, cap_taken};
          ent_enable = ONE << hit_idx;
          mispredict = pred ^ cap_taken;
        end else begin
          ent_op     = {2'b10, cap_taken};
          ent_enable = ONE << victim;
          mispredict = cap_taken;
        end
      end
      default: ;
    endcase
  end

  assign busy          = (state != S_IDLE);
  assign upd_ready     = (state == S_IDLE) & ~clear_any & ~rst;
  assign ent_in_pc     = cap_tag;
  assign ent_in_target = cap_target;

  // Fetch-side lookup merge.
  assign lookup_hit    = |ent_hit;
  assign lookup_taken  = lookup_hit ? ent_prediction[lk_idx] : 1'b0;
  assign lookup_target = lookup_hit ? ent_target[16*lk_idx +: 16] : 16'h0000;

endmodule

// File: tb/tb_btb_ctrl.sv
// tb/tb_btb_ctrl.sv - self-checking bench for btb_ctrl
module tb_btb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic [3:0]  ent_hit;
  logic [3:0]  ent_update_hit;
  logic [3:0]  ent_empty;
  logic [3:0]  ent_prediction;
  logic [63:0] ent_target;
  logic [3:0]  ent_enable;
  logic [2:0]  ent_op;
  logic [10:0] ent_in_pc;
  logic [15:0] ent_in_target;
  logic        lookup_hit;
  logic        lookup_taken;
  logic [15:0] lookup_target;
  logic        mispredict;
  logic        busy;

  btb_ctrl #(.N_ENTRIES(4), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .ent_hit(ent_hit), .ent_update_hit(ent_update_hit), .ent_empty(ent_empty),
    .ent_prediction(ent_prediction), .ent_target(ent_target),
    .ent_enable(ent_enable), .ent_op(ent_op), .ent_in_pc(ent_in_pc),
    .ent_in_target(ent_in_target), .lookup_hit(lookup_hit),
    .lookup_taken(lookup_taken), .lookup_target(lookup_target),
    .mispredict(mispredict), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  en;
    logic        mis;
    logic [10:0] tag;
    logic [15:0] tgt;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [1:0] m_rr = 2'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model of one resolution, evaluated from the slot status the
  // bench is presenting while the update is accepted.
  task automatic push_expected();
    exp_t e;
    int   idx;
    e.tag = upd_pc[15:5];
    e.tgt = upd_target;
    if (ent_update_hit != 4'b0000) begin
      idx = 0;
      while (!ent_update_hit[idx]) idx++;
      e.op  = {2'b01, upd_taken};
      e.en  = 4'b0001 << idx;
      e.mis = ent_prediction[idx] != upd_taken;
    end else begin
      if (ent_empty != 4'b0000) begin
        idx = 0;
        while (!ent_empty[idx]) idx++;
      end else begin
        idx  = int'(m_rr);
        m_rr = m_rr + 2'd1;
      end
      e.op  = {2'b10, upd_taken};
      e.en  = 4'b0001 << idx;
      e.mis = upd_taken;
    end
    sb.push_back(e);
  endtask

  // Scoreboard side: every VERIFY/INSERT cycle must match the next expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (ent_op[2] != ent_op[1]) begin
        exp_t e;
        if (sb.size() == 0) begin
          check("unexpected_issue", {29'd0, ent_op}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("issue_op", {29'd0, ent_op}, {29'd0, e.op});
          check("issue_enable", {28'd0, ent_enable}, {28'd0, e.en});
          check("issue_mispredict", {31'd0, mispredict}, {31'd0, e.mis});
          check("issue_in_pc", {21'd0, ent_in_pc}, {21'd0, e.tag});
          check("issue_in_target", {16'd0, ent_in_target}, {16'd0, e.tgt});
        end
      end else begin
        check("mispredict_idle", {31'd0, mispredict}, 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the RESOLVE cycle.
  task automatic single_update(input logic [15:0] pc, input logic [15:0] tgt,
                               input logic tk, input bit do_push);
    int n = 0;
    upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_valid = 1'b1;
    while (!upd_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_timeout", {31'd0, upd_ready}, 32'd1);
    if (do_push) push_expected();
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  initial begin
    int acc_cyc[5];
    int cnt;
    int n;
    bit found;

    rst = 1'b1; clear_req = 1'b0; upd_valid = 1'b0;
    upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
    ent_hit = '0; ent_update_hit = '0; ent_empty = 4'b1111; ent_prediction = '0;
    ent_target = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    repeat (3) @(negedge clk);
    check("ready_in_reset", {31'd0, upd_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_op", {29'd0, ent_op}, 32'd0);
    check("rst_enable", {28'd0, ent_enable}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, upd_ready}, 32'd1);

    // Lookup merge: lowest-index hit selects the slot.
    ent_hit = 4'b0110; ent_prediction = 4'b0100; #1;
    check("lk_hit_a", {31'd0, lookup_hit}, 32'd1);
    check("lk_taken_a", {31'd0, lookup_taken}, 32'd0);
    check("lk_target_a", {16'd0, lookup_target}, 32'hBBBB);
    ent_hit = 4'b0100; #1;
    check("lk_taken_b", {31'd0, lookup_taken}, 32'd1);
    check("lk_target_b", {16'd0, lookup_target}, 32'hCCCC);
    ent_hit = 4'b1000; #1;
    check("lk_target_c", {16'd0, lookup_target}, 32'hDDDD);
    ent_hit = 4'b0000; #1;
    check("lk_miss_hit", {31'd0, lookup_hit}, 32'd0);
    check("lk_miss_target", {16'd0, lookup_target}, 32'd0);
    ent_prediction = 4'b0000;
    @(negedge clk);

    // Single-cycle flush.
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check("clr_op", {29'd0, ent_op}, 32'h7);
    check("clr_enable", {28'd0, ent_enable}, 32'hF);
    check("clr_ready", {31'd0, upd_ready}, 32'd0);
    @(negedge clk);
    check("clr_after_op", {29'd0, ent_op}, 32'd0);
    check("clr_after_busy", {31'd0, busy}, 32'd0);
    check("clr_after_ready", {31'd0, upd_ready}, 32'd1);

    // Insert into an empty bank: slot 0, tag 0x092.
    single_update(16'h1240, 16'h2000, 1'b1, 1'b1);
    check("resolve_busy", {31'd0, busy}, 32'd1);
    check("resolve_op", {29'd0, ent_op}, 32'd0);
    repeat (2) @(negedge clk);

    // Verify on slot 2 with a taken prediction.
    ent_empty = 4'b0000; ent_update_hit = 4'b0100; ent_prediction = 4'b0100;
    single_update(16'h3460, 16'h0100, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    single_update(16'h3460, 16'h0100, 1'b1, 1'b1);
    repeat (2) @(negedge clk);

    // Full bank, five back-to-back misses: round-robin victims.
    ent_update_hit = 4'b0000; ent_prediction = 4'b0000;
    cnt = 0; n = 0;
    upd_valid = 1'b1;
    while (cnt < 5 && n < 60) begin
      upd_pc = 16'h4000 + 16'(cnt * 32);
      upd_target = 16'h8000 + 16'(cnt);
      upd_taken = cnt[0];
      if (upd_ready) begin
        acc_cyc[cnt] = cyc;
        push_expected();
        cnt++;
      end
      @(negedge clk);
      n++;
    end
    upd_valid = 1'b0;
    check("rr_accept_count", cnt, 32'd5);
    for (int i = 1; i < 5; i++) check("rr_gap", acc_cyc[i] - acc_cyc[i-1], 32'd3);
    repeat (3) @(negedge clk);

    // Flush arriving during RESOLVE waits for the in-flight ISSUE.
    single_update(16'h5000, 16'h9000, 1'b1, 1'b1);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check("pend_issue_busy", {31'd0, busy}, 32'd1);
    check("pend_issue_ready", {31'd0, upd_ready}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (!found && ent_op == 3'b111) begin
        found = 1'b1;
        check("pend_clr_enable", {28'd0, ent_enable}, 32'hF);
      end
    end
    check("pend_clr_seen", {31'd0, found}, 32'd1);
    m_rr = 2'd0;
    @(negedge clk);
    single_update(16'h6000, 16'hA000, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // Reset during RESOLVE abandons the update.
    single_update(16'h7000, 16'hB000, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_enable", {28'd0, ent_enable}, 32'd0);
    check("abort_op", {29'd0, ent_op}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
